// File: rtl/hilo_div_unit_pkg.sv
// Shared constants for the HI/LO divider: data width, state encodings and
// handshake levels.
package hilo_div_unit_pkg;

    localparam int REG_DATA_W = 32;

    localparam logic [REG_DATA_W-1:0] ZERO_WORD = '0;

    // 2-bit state encodings kept numerically stable for legacy compatibility
    localparam logic [1:0] DIV_FREE    = 2'b00;
    localparam logic [1:0] DIV_BY_ZERO = 2'b01;
    localparam logic [1:0] DIV_ON      = 2'b10;
    localparam logic [1:0] DIV_END     = 2'b11;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

    localparam logic DIV_START = 1'b1;
    localparam logic DIV_STOP  = 1'b0;

endpackage

// File: rtl/hilo_div_unit.sv
// Iterative radix-2 restoring divider feeding the HI/LO write port.
// Quotient -> LO, remainder -> HI; one quotient bit per clock, 32 clocks total.
module hilo_div_unit
    import hilo_div_unit_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                annul_i,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o,
    output logic                stall_o,
    output logic                we_o,
    output logic [DATA_W-1:0]   hi_o,
    output logic [DATA_W-1:0]   lo_o
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v,
                                                  input logic              sgn);
        return (sgn && v[DATA_W-1]) ? (~v + 1'b1) : v;
    endfunction

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] dvd;     // dividend bits shift out the top, quotient bits in the bottom
    logic [DATA_W-1:0] dvs;
    logic              neg_quo;
    logic              neg_rem;

    logic [DATA_W:0]   trial;
    logic              no_borrow;
    logic [DATA_W-1:0] rem_nxt;
    logic [DATA_W-1:0] quo_nxt;
    logic [DATA_W-1:0] quo_fix;
    logic [DATA_W-1:0] rem_fix;

    // Full-width partial remainder in the subtract so divisors >= 2^(W-1) stay exact
    always_comb begin
        trial     = {rem, dvd[DATA_W-1]} - {1'b0, dvs};
        no_borrow = ~trial[DATA_W];
        rem_nxt   = no_borrow ? trial[DATA_W-1:0] : {rem[DATA_W-2:0], dvd[DATA_W-1]};
        quo_nxt   = {dvd[DATA_W-2:0], no_borrow};
        quo_fix   = neg_quo ? (~quo_nxt + 1'b1) : quo_nxt;
        rem_fix   = neg_rem ? (~rem_nxt + 1'b1) : rem_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= DIV_FREE;
            cnt      <= '0;
            rem      <= '0;
            dvd      <= '0;
            dvs      <= '0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            result_o <= {ZERO_WORD, ZERO_WORD};
            ready_o  <= DIV_RESULT_NOT_READY;
            we_o     <= 1'b0;
        end else begin
            case (state)
                DIV_FREE: begin
                    we_o    <= 1'b0;
                    ready_o <= DIV_RESULT_NOT_READY;
                    if (start_i == DIV_START && !annul_i) begin
                        if (opdata2_i == ZERO_WORD) begin
                            state <= DIV_BY_ZERO;
                        end else begin
                            state   <= DIV_ON;
                            dvd     <= abs_val(opdata1_i, signed_div_i);
                            dvs     <= abs_val(opdata2_i, signed_div_i);
                            neg_quo <= signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                            neg_rem <= signed_div_i & opdata1_i[DATA_W-1];
                            rem     <= '0;
                            cnt     <= '0;
                        end
                    end
                end
                DIV_BY_ZERO: begin
                    if (annul_i) begin
                        state <= DIV_FREE;
                    end else begin
                        state    <= DIV_END;
                        result_o <= {ZERO_WORD, ZERO_WORD};
                        ready_o  <= DIV_RESULT_READY;
                        we_o     <= 1'b1;
                    end
                end
                DIV_ON: begin
                    if (annul_i) begin
                        state <= DIV_FREE;
                    end else begin
                        rem <= rem_nxt;
                        dvd <= quo_nxt;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_CNT) begin
                            state    <= DIV_END;
                            result_o <= {rem_fix, quo_fix};
                            ready_o  <= DIV_RESULT_READY;
                            we_o     <= 1'b1;
                        end
                    end
                end
                DIV_END: begin
                    // Write already issued on entry; annul has nothing left to cancel
                    we_o <= 1'b0;
                    if (start_i == DIV_STOP) begin
                        state    <= DIV_FREE;
                        ready_o  <= DIV_RESULT_NOT_READY;
                        result_o <= {ZERO_WORD, ZERO_WORD};
                    end
                end
                default: state <= DIV_FREE;
            endcase
        end
    end

    assign stall_o = ((state == DIV_FREE) && start_i && !annul_i)
                   || (state == DIV_ON) || (state == DIV_BY_ZERO);

    assign hi_o = result_o[2*DATA_W-1:DATA_W];
    assign lo_o = result_o[DATA_W-1:0];

endmodule

// File: tb/tb_hilo_div_unit.sv
// Directed bench for hilo_div_unit: arithmetic reference model plus per-cycle
// output compare and hand-computed quotient/remainder literals.
module tb_hilo_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = '0;
    logic [31:0] opdata2_i = '0;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stall_o;
    logic        we_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int          errors = 0;
    int          checks = 0;
    int          we_count = 0;
    logic        chk_en = 1'b0;
    logic [63:0] exp_res = '0;

    hilo_div_unit dut (
        .clk(clk), .rst(rst), .start_i(start_i), .annul_i(annul_i),
        .signed_div_i(signed_div_i), .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
        .result_o(result_o), .ready_o(ready_o), .stall_o(stall_o), .we_o(we_o),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    // {remainder, quotient} from plain language arithmetic; 64-bit signed math
    // makes 0x80000000 / -1 come out as 0x80000000 without overflow.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
        longint sa, sb, q, r;
        if (b == 0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Outputs are meaningful every cycle: the model result while ready, zero otherwise
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("result", result_o, ready_o ? exp_res : 64'd0);
            check("hilo", {hi_o, lo_o}, ready_o ? exp_res : 64'd0);
            check("we_only_when_ready", {63'd0, we_o & ~ready_o}, 64'd0);
            if (we_o) we_count++;
        end
    end

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           input int hold, input logic [31:0] lit_lo,
                           input logic [31:0] lit_hi, input string tag);
        int edges;
        int we0;
        exp_res = model(a, b, sgn);
        @(negedge clk);
        opdata1_i = a; opdata2_i = b; signed_div_i = sgn; start_i = 1'b1;
        we0 = we_count;
        #1 check({tag, " stall_req"}, {63'd0, stall_o}, 64'd1);
        @(posedge clk); #1;
        edges = 1;
        // operands are don't-care after the accept edge
        opdata1_i = ~a; opdata2_i = b ^ 32'h5a5a_0001;
        while (!ready_o && edges < 100) begin
            @(posedge clk); #1;
            edges++;
        end
        check({tag, " latency"}, 64'(edges), (b == 0) ? 64'd2 : 64'd33);
        check({tag, " we_first"}, {63'd0, we_o}, 64'd1);
        check({tag, " stall_done"}, {63'd0, stall_o}, 64'd0);
        check({tag, " lo"}, {32'd0, lo_o}, {32'd0, lit_lo});
        check({tag, " hi"}, {32'd0, hi_o}, {32'd0, lit_hi});
        repeat (hold) begin
            @(posedge clk); #1;
            check({tag, " hold_ready"}, {62'd0, ready_o, we_o}, 64'd2);
        end
        @(negedge clk) start_i = 1'b0;
        @(posedge clk); #1;
        check({tag, " idle_ready"}, {63'd0, ready_o}, 64'd0);
        check({tag, " we_pulses"}, 64'(we_count - we0), 64'd1);
    endtask

    initial begin
        int we0;
        #1;
        check("reset_state", {result_o, 28'd0, ready_o, we_o, stall_o, 1'b0}, 96'd0);
        @(negedge clk) rst = 1'b0;
        chk_en = 1'b1;

        run_div(32'd100, 32'd7, 1'b0, 0, 32'd14, 32'd2, "u100_7");
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "s-7_2");
        run_div(32'd7, 32'hFFFF_FFFE, 1'b1, 0, 32'hFFFF_FFFD, 32'd1, "s7_-2");
        run_div(32'd1234, 32'd0, 1'b0, 0, 32'd0, 32'd0, "u_div0");
        run_div(32'h8000_0000, 32'd0, 1'b1, 0, 32'd0, 32'd0, "s_div0");
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 32'h8000_0000, 32'd0, "s_min_-1");
        run_div(32'hFFFF_FFFF, 32'd1, 1'b0, 0, 32'hFFFF_FFFF, 32'd0, "u_max_1");
        run_div(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 0, 32'd1, 32'd1, "u_big_div");
        run_div(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 0, 32'd14, 32'hFFFF_FFFE, "s-100_-7");
        run_div(32'd20, 32'd6, 1'b0, 5, 32'd3, 32'd2, "hold5");

        // annul while idle blocks acceptance
        @(negedge clk) start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd9; opdata2_i = 32'd3;
        #1 check("annul_idle_stall", {63'd0, stall_o}, 64'd0);
        @(posedge clk); #1 check("annul_idle_stay", {62'd0, stall_o, ready_o}, 64'd0);
        @(negedge clk) start_i = 1'b0; annul_i = 1'b0;

        // annul at BUSY iteration 10
        we0 = we_count;
        exp_res = 64'd0;
        @(negedge clk) start_i = 1'b1; signed_div_i = 1'b0;
        opdata1_i = 32'hDEAD_BEEF; opdata2_i = 32'd3;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk) start_i = 1'b0; annul_i = 1'b1;
        #1 check("annul_busy_stall", {63'd0, stall_o}, 64'd1);
        @(posedge clk); #1 check("annul_busy_idle", {62'd0, stall_o, ready_o}, 64'd0);
        annul_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("annul_busy_no_we", 64'(we_count - we0), 64'd0);
        run_div(32'd50, 32'd5, 1'b0, 0, 32'd10, 32'd0, "after_annul");

        // annul during divide-by-zero cycle
        we0 = we_count;
        @(negedge clk) start_i = 1'b1; opdata1_i = 32'd5; opdata2_i = 32'd0;
        @(posedge clk); #1;
        start_i = 1'b0; annul_i = 1'b1;
        @(posedge clk); #1 check("annul_dz_idle", {62'd0, stall_o, ready_o}, 64'd0);
        annul_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("annul_dz_no_we", 64'(we_count - we0), 64'd0);

        // async reset mid-BUSY
        we0 = we_count;
        exp_res = model(32'd1000, 32'd3, 1'b0);
        @(negedge clk) start_i = 1'b1; opdata1_i = 32'd1000; opdata2_i = 32'd3;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #2 check("pre_rst_stall", {63'd0, stall_o}, 64'd1);
        rst = 1'b1; start_i = 1'b0;
        #1 check("rst_busy_outputs", {result_o, 29'd0, ready_o, we_o, stall_o}, 96'd0);
        @(negedge clk) rst = 1'b0;
        repeat (40) @(posedge clk);
        #1 check("rst_busy_no_we", 64'(we_count - we0), 64'd0);

        // async reset while holding a finished result
        exp_res = model(32'd9, 32'd4, 1'b0);
        @(negedge clk) start_i = 1'b1; opdata1_i = 32'd9; opdata2_i = 32'd4;
        begin
            int n = 0;
            @(posedge clk); #1;
            while (!ready_o && n < 100) begin @(posedge clk); #1; n++; end
        end
        check("pre_rst_done_hi_lo", {hi_o, lo_o}, {32'd1, 32'd2});
        #2 rst = 1'b1; start_i = 1'b0;
        #1 check("rst_done_outputs", {result_o, 29'd0, ready_o, we_o, stall_o}, 96'd0);
        @(negedge clk) rst = 1'b0;
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
